cordic_rot_sequencer: RTL and testbench
=======================================

Name: cordic_rot_sequencer

Overview:
- Iterative rotation-mode CORDIC sequencer for the signed 8-bit angle/vector path.
- Accepts one (x, y, z) job per start pulse. Applies quadrant pre-rotation by conditional two's-complement negation, then steps ITER shift-add micro-rotations.
- Presents the rotated vector with a one-cycle done pulse.
- Sits between the host/control logic and the shared shift-add datapath registers, and owns the iteration counter and the arctangent schedule.

Parameters:
- W, 8, input data width (x, y, z), signed two's complement.
- ITER, 8, number of micro-rotations; legal range 1..8, bounded by the 8-entry arctangent table.
- GW, 2, guard bits added to the x/y datapath; output width is W+GW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  job request; sampled only in IDLE.
- x_in  input  W  signed vector x.
- y_in  input  W  signed vector y.
- z_in  input  W  signed binary angle; 2^(W-1) = pi, so 64 = 90 deg and -128 = -180 deg at W=8.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; results valid.
- x_out  output  W+GW  rotated x, scaled by CORDIC gain K≈1.647 (no compensation).
- y_out  output  W+GW  rotated y, scaled by K.
- z_res  output  W  residual angle after the last iteration.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: rst_n=0 at a rising edge forces state=IDLE, busy=0, done=0, x_out=y_out=0, z_res=0 and iteration counter=0.
  - Reset mid-job aborts the job; no done is produced.
- State machine:
  - IDLE -> PRE on start=1. x_in, y_in, z_in are captured, sign-extended to W+GW.
  - PRE (1 cycle) -> ROT.
    - If z[W-1]^z[W-2]=1 (|angle| ≥ 90 deg): x=-x, y=-y, z={~z[W-1], z[W-2:0]} (angle ± pi).
    - Otherwise the values pass unchanged.
    - Negation is exact two's complement at W+GW bits; no overflow is possible thanks to the guard bits.
  - ROT (ITER cycles, counter i = 0..ITER-1):
    - d = +1 if z ≥ 0, else -1.
    - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
    - Shifts are arithmetic. All three updates use pre-update values in the same cycle.
    - After i = ITER-1 -> DONE.
  - DONE (1 cycle):
    - done=1. x_out, y_out, z_res load the final values.
    - -> IDLE.
- Latency: done is asserted ITER+2 cycles after the clock edge that samples start (10 cycles at ITER=8).
- Output hold: x_out, y_out, z_res hold their value until the next DONE or reset. done is low in every other cycle.
- start is ignored while busy=1; no queuing. start=1 in the DONE cycle is also ignored. A new job is accepted on the first IDLE cycle.
- ATAN[i] in binary-angle units (128=pi): 32, 19, 10, 5, 3, 1, 1, 0.
- z arithmetic wraps modulo 2^W. After pre-rotation |z| ≤ 64, within the convergence range (about ±71).
- Edge inputs:
  - x_in = y_in = -128 is legal.
  - Maximum output magnitude is ≈ 128*1.414*1.647 ≈ 298, which fits in 10 bits.

Decomposition:
- Shared package/include cordic_pkg:
  - ATAN table constant.
  - State encoding: IDLE, PRE, ROT, DONE.
  - Binary-angle constants HALF_PI=64 and PI=128.
- One natural sub-module: cordic_cond_negate.
  - Parameterised width.
  - Output equals the input when neg=0, and the two's complement when neg=1.
  - Instantiated twice in PRE for x and y.

Test Plan:
- Reset, then x=100, y=0, z=0, start -> done exactly 10 cycles later; x_out=165±3, y_out=0±3, busy high for 10 cycles.
- x=100, y=0, z=64 (90 deg) -> pre-rotation taken; x_out=0±3, y_out=165±3.
- x=100, y=0, z=-128 (-180 deg) -> x_out=-165±3, y_out=0±3; the z wrap produces no spurious sign error.
- x=-128, y=-128, z=32 -> no overflow; x_out=0±4, y_out=-298±4.
- start re-pulsed on cycles 3 and 9 of a job -> ignored; exactly one done; outputs reflect the first job only.
- rst_n=0 for one cycle mid-ROT -> next cycle busy=0, outputs 0, no done; a fresh start then completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants, FSM encoding and arctangent schedule.
package cordic_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ROT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int HALF_PI = 64;
  localparam int PI      = 128;
  // Binary-angle arctangent schedule, 128 = pi; element [i] is atan(2^-i).
  localparam logic [7:0][7:0] ATAN = {8'd0, 8'd1, 8'd1, 8'd3, 8'd5, 8'd10, 8'd19, 8'd32};
endpackage

// File: rtl/cordic_cond_negate.sv
// cordic_cond_negate: passes a through, or its two's complement when neg is set.
module cordic_cond_negate #(
  parameter int N = 10
) (
  input  logic [N-1:0] a,
  input  logic         neg,
  output logic [N-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/cordic_rot_sequencer.sv
// cordic_rot_sequencer: iterative rotation-mode CORDIC with quadrant pre-rotation.
module cordic_rot_sequencer
  import cordic_pkg::*;
#(
  parameter int W    = 8,
  parameter int ITER = 8,
  parameter int GW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    x_in,
  input  logic [W-1:0]    y_in,
  input  logic [W-1:0]    z_in,
  output logic            busy,
  output logic            done,
  output logic [W+GW-1:0] x_out,
  output logic [W+GW-1:0] y_out,
  output logic [W-1:0]    z_res
);
  localparam int XW = W + GW;
  logic [1:0] state_q, state_d;
  logic [2:0] i_q, i_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_out_q, x_out_d, y_out_q, y_out_d;
  logic signed [XW-1:0] x_neg, y_neg, x_sh, y_sh, x_rot, y_rot;
  logic signed [W-1:0]  z_q, z_d, z_res_q, z_res_d, z_rot, a;
  logic pre_neg, dpos, last;
  assign pre_neg = z_q[W-1] ^ z_q[W-2];
  cordic_cond_negate #(.N(XW)) u_neg_x (.a(x_q), .neg(pre_neg), .y(x_neg));
  cordic_cond_negate #(.N(XW)) u_neg_y (.a(y_q), .neg(pre_neg), .y(y_neg));
  // One micro-rotation; all three updates read the pre-update registers.
  always_comb begin
    dpos  = ~z_q[W-1];
    x_sh  = x_q >>> i_q;
    y_sh  = y_q >>> i_q;
    a     = W'(ATAN[i_q]);
    x_rot = dpos ? x_q - y_sh : x_q + y_sh;
    y_rot = dpos ? y_q + x_sh : y_q - x_sh;
    z_rot = dpos ? z_q - a : z_q + a;
    last  = i_q == 3'(ITER - 1);
  end
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_res_d = z_res_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PRE;
        x_d     = {{GW{x_in[W-1]}}, x_in};
        y_d     = {{GW{y_in[W-1]}}, y_in};
        z_d     = z_in;
      end
      S_PRE: begin
        state_d = S_ROT;
        i_d     = '0;
        x_d     = x_neg;
        y_d     = y_neg;
        z_d     = pre_neg ? {~z_q[W-1], z_q[W-2:0]} : z_q;
      end
      S_ROT: begin
        state_d = last ? S_DONE : S_ROT;
        i_d     = last ? '0 : i_q + 3'd1;
        x_d     = x_rot;
        y_d     = y_rot;
        z_d     = z_rot;
        x_out_d = last ? x_rot : x_out_q;
        y_out_d = last ? y_rot : y_out_q;
        z_res_d = last ? z_rot : z_res_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_res_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_res_q <= z_res_d;
    end
  end
  assign busy  = state_q != S_IDLE;
  assign done  = state_q == S_DONE;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_res = z_res_q;
endmodule

// File: tb/tb_cordic_rot_sequencer.sv
// tb_cordic_rot_sequencer: randomized and directed checks against an integer CORDIC model.
module tb_cordic_rot_sequencer;
  localparam int W = 8, ITER = 8, GW = 2;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic busy, done;
  logic [W+GW-1:0] x_out, y_out;
  logic [W-1:0] z_res;
  int checks = 0, failures = 0;
  int atan_tab [8] = '{32, 19, 10, 5, 3, 1, 1, 0};
  always #5 clk = ~clk;
  cordic_rot_sequencer #(.W(W), .ITER(ITER), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .z_res(z_res)
  );
  function automatic int wrap(input int v);
    return ((v + 128) & 255) - 128;
  endfunction
  function automatic void model(input int xi, yi, zi, output int xo, yo, zo);
    int x = xi, y = yi, z = zi, xn, d;
    if (z >= 64 || z < -64) begin
      x = -x;
      y = -y;
      z = wrap(z + 128);
    end
    for (int i = 0; i < ITER; i++) begin
      d  = z >= 0 ? 1 : -1;
      xn = x - d * (y >>> i);
      y  = y + d * (x >>> i);
      x  = xn;
      z  = wrap(z - d * atan_tab[i]);
    end
    xo = x; yo = y; zo = z;
  endfunction
  function automatic int absi(input int v);
    return v < 0 ? -v : v;
  endfunction
  task automatic run_job(input int x, y, z, input int pmask,
                         output int ox, oy, oz, lat, bcnt, nd);
    x_in = W'(x); y_in = W'(y); z_in = W'(z);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = -1; bcnt = 0; nd = 0; ox = 0; oy = 0; oz = 0;
    for (int k = 1; k <= 14; k++) begin
      if (busy) bcnt++;
      if (done) begin
        nd++;
        if (lat < 0) begin
          lat = k; ox = $signed(x_out); oy = $signed(y_out); oz = $signed(z_res);
        end
      end
      start = pmask[k];
      @(posedge clk); #1;
    end
    start = 0;
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || x_out !== '0 || y_out !== '0 || z_res !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b x=%0d y=%0d z=%0d want all 0", busy, done, x_out, y_out, z_res);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_directed;
    int vx [4] = '{100, 100, 100, -128};
    int vy [4] = '{0, 0, 0, -128};
    int vz [4] = '{0, 64, -128, 32};
    int ex [4] = '{165, 0, -165, 0};
    int ey [4] = '{0, 165, 0, -298};
    int tol [4] = '{3, 3, 3, 4};
    int ox, oy, oz, lat, bcnt, nd, mx, my, mz;
    for (int t = 0; t < 4; t++) begin
      run_job(vx[t], vy[t], vz[t], 0, ox, oy, oz, lat, bcnt, nd);
      model(vx[t], vy[t], vz[t], mx, my, mz);
      checks++;
      if (lat != ITER + 2 || nd != 1) begin
        failures++;
        $display("FAIL dir%0d_latency: lat=%0d dones=%0d want lat=%0d dones=1", t, lat, nd, ITER + 2);
      end
      checks++;
      if (bcnt != ITER + 2) begin
        failures++;
        $display("FAIL dir%0d_busy: busy_cycles=%0d want %0d", t, bcnt, ITER + 2);
      end
      checks++;
      if (absi(ox - ex[t]) > tol[t] || absi(oy - ey[t]) > tol[t]) begin
        failures++;
        $display("FAIL dir%0d_approx: x=%0d y=%0d want %0d,%0d +-%0d", t, ox, oy, ex[t], ey[t], tol[t]);
      end
      checks++;
      if (ox != mx || oy != my || oz != mz) begin
        failures++;
        $display("FAIL dir%0d_exact: x=%0d y=%0d z=%0d want %0d %0d %0d", t, ox, oy, oz, mx, my, mz);
      end
    end
  endtask
  task automatic test_random;
    int x, y, z, ox, oy, oz, lat, bcnt, nd, mx, my, mz;
    for (int t = 0; t < 24; t++) begin
      x = int'($urandom_range(255)) - 128;
      y = int'($urandom_range(255)) - 128;
      z = int'($urandom_range(255)) - 128;
      run_job(x, y, z, 0, ox, oy, oz, lat, bcnt, nd);
      model(x, y, z, mx, my, mz);
      checks++;
      if (lat != ITER + 2 || nd != 1 || ox != mx || oy != my || oz != mz) begin
        failures++;
        $display("FAIL rand%0d in=(%0d,%0d,%0d): lat=%0d dones=%0d out=(%0d,%0d,%0d) want lat=%0d out=(%0d,%0d,%0d)",
                 t, x, y, z, lat, nd, ox, oy, oz, ITER + 2, mx, my, mz);
      end
    end
  endtask
  task automatic test_back_to_back;
    int ox, oy, oz, lat, bcnt, nd, mx, my, mz;
    run_job(-77, 51, 100, (1 << 3) | (1 << 9) | (1 << 10), ox, oy, oz, lat, bcnt, nd);
    model(-77, 51, 100, mx, my, mz);
    checks++;
    if (nd != 1 || bcnt != ITER + 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_ignored: dones=%0d busy_cycles=%0d busy_now=%b want 1 %0d 0", nd, bcnt, busy, ITER + 2);
    end
    checks++;
    if (ox != mx || oy != my || oz != mz) begin
      failures++;
      $display("FAIL restart_result: out=(%0d,%0d,%0d) want (%0d,%0d,%0d)", ox, oy, oz, mx, my, mz);
    end
  endtask
  task automatic test_hold;
    int bad = 0, mx, my, mz;
    model(-77, 51, 100, mx, my, mz);
    for (int k = 0; k < 6; k++) begin
      if (done !== 1'b0 || $signed(x_out) != mx || $signed(y_out) != my || $signed(z_res) != mz) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL output_hold: bad_cycles=%0d want 0", bad);
    end
  endtask
  task automatic test_mid_reset;
    int nd = 0, ox, oy, oz, lat, bcnt, mx, my, mz;
    x_in = 8'd90; y_in = 8'd40; z_in = 8'd20;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || x_out !== '0 || y_out !== '0 || z_res !== '0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b done=%b x=%0d y=%0d z=%0d want all 0", busy, done, x_out, y_out, z_res);
    end
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL mid_reset_abort: active_cycles=%0d want 0", nd);
    end
    run_job(90, 40, 20, 0, ox, oy, oz, lat, bcnt, nd);
    model(90, 40, 20, mx, my, mz);
    checks++;
    if (lat != ITER + 2 || nd != 1 || ox != mx || oy != my || oz != mz) begin
      failures++;
      $display("FAIL post_reset_job: lat=%0d dones=%0d out=(%0d,%0d,%0d) want lat=%0d out=(%0d,%0d,%0d)",
               lat, nd, ox, oy, oz, ITER + 2, mx, my, mz);
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_hold;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
